// File: rtl/vram_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vram_scanout
// Purpose  : Video-side line fetcher. During horizontal blanking it reads one
//            source line of packed 4-bit pixels from VRAM port B into a line
//            buffer. During the active area it unpacks the buffer into one
//            colour per pixel clock. Each source pixel is doubled in both
//            directions, so a 320x240 framebuffer fills a 640x480 display.
// Ports    : clk, reset (async, active-high)
//            line_req/line_y     - fetch request and the display line it is for
//            pix_x/pix_active    - current display column / visible area
//            vram_addr/vram_rdata- VRAM port B (read data 1 clk after address)
//            col                 - registered pixel colour (1 clk latency)
//            busy                - fetch in progress
//            overrun             - sticky: line_req arrived while busy
// Revision : 1.0 - initial release
// ============================================================================
module vram_scanout #(
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter logic [29:0] VRAM_BASE = 30'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_req,
  input  logic [9:0]  line_y,
  input  logic [9:0]  pix_x,
  input  logic        pix_active,
  output logic [29:0] vram_addr,
  input  logic [31:0] vram_rdata,
  output logic [3:0]  col,
  output logic        busy,
  output logic        overrun
);

  localparam int            WORDS_PER_LINE = H_RES / 8;
  localparam int            KW             = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [KW-1:0] K_LAST         = KW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [KW-1:0] word_cnt;
  logic          line_blank;

  // Capture pipeline: one bit per issued address, aligned with the read data.
  logic          cap_valid;
  logic [KW-1:0] cap_idx;

  logic [31:0]   line_buf [WORDS_PER_LINE];

  // Request decode: source line is the display line halved.
  logic [8:0]  req_sy;
  logic        req_ok;
  logic [29:0] line_start;

  assign req_sy     = line_y[9:1];
  assign req_ok     = (32'(req_sy) < V_RES);
  assign line_start = VRAM_BASE + 30'(req_sy) * 30'(WORDS_PER_LINE);

  // Read side: source column is the display column halved.
  logic [8:0]    sx;
  logic          sx_ok;
  logic [KW-1:0] rd_idx;
  logic [31:0]   rd_word;

  assign sx      = pix_x[9:1];
  assign sx_ok   = (32'(sx) < H_RES);
  assign rd_idx  = KW'(sx >> 3);
  assign rd_word = line_buf[rd_idx];

  // The LSBs are discarded by the pixel doubling.
  logic unused_lsbs;
  assign unused_lsbs = ^{pix_x[0], line_y[0]};

  // Fetch control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      vram_addr  <= VRAM_BASE;
      line_blank <= 1'b1;
      word_cnt   <= '0;
      cap_valid  <= 1'b0;
      cap_idx    <= '0;
    end else begin
      // Every FETCH cycle presents an address whose data lands next cycle,
      // including one presented on the cycle a restart is accepted.
      cap_valid <= (state == FETCH);
      cap_idx   <= word_cnt;

      if (line_req) begin
        if (busy) begin
          overrun <= 1'b1;
        end
        word_cnt <= '0;
        if (req_ok) begin
          line_blank <= 1'b0;
          state      <= FETCH;
          busy       <= 1'b1;
          vram_addr  <= line_start;
        end else begin
          // Off-screen line: blank it and abandon any fetch in progress.
          line_blank <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
        end
      end else begin
        case (state)
          FETCH: begin
            if (word_cnt == K_LAST) begin
              state <= DRAIN;
            end else begin
              word_cnt  <= word_cnt + KW'(1);
              vram_addr <= vram_addr + 30'd1;
            end
          end
          DRAIN: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Line buffer is storage only; its contents are not reset.
  always_ff @(posedge clk) begin
    if (cap_valid) begin
      line_buf[cap_idx] <= vram_rdata;
    end
  end

  // Colour output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= 4'd0;
    end else if (!pix_active || line_blank || !sx_ok) begin
      col <= 4'd0;
    end else begin
      col <= rd_word[{sx[2:0], 2'b00} +: 4];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_scanout
// Purpose  : Self-checking bench for vram_scanout. A VRAM model answers reads
//            one clock after the address. Expected address/busy/overrun and
//            colour values are computed from the framebuffer contents and
//            pushed into queues; a monitor pops and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_scanout;

  localparam int          H_RES     = 320;
  localparam int          V_RES     = 240;
  localparam int          WPL       = H_RES / 8;
  localparam logic [29:0] BASE      = 30'h0001_0000;
  localparam int          MEM_WORDS = V_RES * WPL;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_req;
  logic [9:0]  line_y;
  logic [9:0]  pix_x;
  logic        pix_active;
  logic [29:0] vram_addr;
  logic [31:0] vram_rdata;
  logic [3:0]  col;
  logic        busy;
  logic        overrun;

  vram_scanout #(
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .VRAM_BASE (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .line_req   (line_req),
    .line_y     (line_y),
    .pix_x      (pix_x),
    .pix_active (pix_active),
    .vram_addr  (vram_addr),
    .vram_rdata (vram_rdata),
    .col        (col),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer and VRAM port B model
  logic [31:0] vmem [MEM_WORDS];

  function automatic logic [31:0] mem_read(input logic [29:0] a);
    logic [29:0] off;
    off = a - BASE;
    if (off < 30'(MEM_WORDS)) return vmem[off];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) vram_rdata <= mem_read(vram_addr);

  // Scoreboard
  typedef struct {
    int          cyc;
    logic [29:0] addr;
    logic        busy;
    logic        ov;
  } st_exp_t;

  typedef struct {
    int       cyc;
    logic [3:0] col;
  } col_exp_t;

  st_exp_t  addr_q[$];
  col_exp_t col_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_first    = 0;
  int          m_busy_end = -1;
  logic [29:0] m_start    = BASE;
  logic [29:0] m_last     = BASE;
  logic        m_ov       = 1'b0;
  logic        m_blank    = 1'b1;
  int          m_sy       = 0;

  // Colour of display column px on the current source line.
  function automatic logic [3:0] exp_col(input logic act, input logic [9:0] px);
    int          sx;
    logic [31:0] w;
    sx = int'(px) / 2;
    if (!act || m_blank || sx >= H_RES) return 4'd0;
    w = vmem[m_sy * WPL + sx / 8];
    return 4'((w >> (4 * (sx % 8))) & 32'hF);
  endfunction

  // Request seen by the DUT at the edge after cycle n.
  task automatic model_request(input int n, input logic [9:0] y);
    int sy;
    bit was_busy;
    int issued;
    sy       = int'(y) / 2;
    was_busy = (n >= m_first) && (n <= m_busy_end);
    if (was_busy) m_ov = 1'b1;
    while (addr_q.size() > 0 && addr_q[$].cyc > n) void'(addr_q.pop_back());
    if (sy < V_RES) begin
      m_blank = 1'b0;
      m_sy    = sy;
      m_first = n + 1;
      m_start = BASE + 30'(sy * WPL);
      for (int i = 0; i < WPL; i++)
        addr_q.push_back(st_exp_t'{n + 1 + i, m_start + 30'(i), 1'b1, m_ov});
      addr_q.push_back(st_exp_t'{n + 1 + WPL, m_start + 30'(WPL - 1), 1'b1, m_ov});
      m_busy_end = n + 1 + WPL;
      m_last     = m_start + 30'(WPL - 1);
    end else begin
      m_blank = 1'b1;
      if (was_busy) begin
        issued = n - m_first;
        if (issued > WPL - 1) issued = WPL - 1;
        m_last = m_start + 30'(issued);
      end
      m_busy_end = n;
    end
  endtask

  task automatic drive(input logic req, input logic [9:0] y, input logic act, input logic [9:0] px);
    int n;
    @(negedge clk);
    line_req   = req;
    line_y     = y;
    pix_active = act;
    pix_x      = px;
    n = cyc;
    col_q.push_back(col_exp_t'{n + 1, exp_col(act, px)});
    if (req) model_request(n, y);
    if (n + 1 > m_busy_end) addr_q.push_back(st_exp_t'{n + 1, m_last, 1'b0, m_ov});
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 10'($urandom_range(0, 1023)), 1'b0, 10'($urandom_range(0, 1023)));
  endtask

  task automatic sweep(input int last_px, input bit rnd_active);
    for (int px = 0; px <= last_px; px++)
      drive(1'b0, 10'($urandom_range(0, 1023)), rnd_active ? ($urandom_range(0, 7) != 0) : 1'b1, 10'(px));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
  task automatic reset_mid_cycle();
    int n;
    @(negedge clk);
    n = cyc;
    line_req   = 1'b0;
    pix_active = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_addr", 32'(vram_addr), 32'(BASE));
    check("async_reset_col", 32'(col), 32'd0);
    check("async_reset_overrun", 32'(overrun), 32'd0);
    while (addr_q.size() > 0 && addr_q[$].cyc > n) void'(addr_q.pop_back());
    while (col_q.size() > 0 && col_q[$].cyc > n) void'(col_q.pop_back());
    m_busy_end = -1;
    m_last     = BASE;
    m_ov       = 1'b0;
    m_blank    = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // Monitor: compares whatever the model expects for the current cycle.
  always @(negedge clk) begin
    st_exp_t  se;
    col_exp_t ce;
    while (addr_q.size() > 0 && addr_q[0].cyc <= cyc) begin
      se = addr_q.pop_front();
      checks++;
      if (se.cyc != cyc || vram_addr !== se.addr || busy !== se.busy || overrun !== se.ov) begin
        errors++;
        $display("FAIL fetch_state cyc %0d/%0d: addr %h busy %b overrun %b, required addr %h busy %b overrun %b",
                 cyc, se.cyc, vram_addr, busy, overrun, se.addr, se.busy, se.ov);
      end
    end
    while (col_q.size() > 0 && col_q[0].cyc <= cyc) begin
      ce = col_q.pop_front();
      checks++;
      if (ce.cyc != cyc || col !== ce.col) begin
        errors++;
        $display("FAIL colour cyc %0d/%0d: col %h required %h", cyc, ce.cyc, col, ce.col);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int y;
    for (int i = 0; i < MEM_WORDS; i++) vmem[i] = $urandom;
    vmem[0] = 32'h7654_3210;
    vmem[1] = 32'hFEDC_BA98;

    reset      = 1'b1;
    line_req   = 1'b0;
    line_y     = 10'd0;
    pix_x      = 10'd0;
    pix_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_addr", 32'(vram_addr), 32'(BASE));
    check("reset_col", 32'(col), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);

    // Line 0 fetch, then unpack/doubling of the first two words.
    idle(2);
    drive(1'b1, 10'd0, 1'b0, 10'd0);
    idle(WPL + 3);
    sweep(31, 1'b0);
    sweep(700, 1'b1);

    // Odd display line maps to source line 1.
    drive(1'b1, 10'd3, 1'b0, 10'd0);
    idle(WPL + 3);
    sweep(660, 1'b0);

    // Off-screen line: no fetch, blank output.
    drive(1'b1, 10'd480, 1'b0, 10'd0);
    idle(5);
    sweep(639, 1'b0);

    // Restart mid-fetch.
    drive(1'b1, 10'd0, 1'b0, 10'd0);
    idle(9);
    drive(1'b1, 10'd2, 1'b0, 10'd0);
    idle(WPL + 3);
    check("restart_overrun", 32'(overrun), 32'd1);
    sweep(650, 1'b1);

    // Reset mid-fetch; same line is refetched so the buffer stays coherent.
    drive(1'b1, 10'd2, 1'b0, 10'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 10'd0, 1'b1, 10'($urandom_range(0, 639)));
    reset_mid_cycle();
    idle(3);
    sweep(100, 1'b0);

    // Randomized lines, with occasional overlapping requests.
    for (int l = 0; l < 10; l++) begin
      y = $urandom_range(0, 599);
      drive(1'b1, 10'(y), 1'b0, 10'd0);
      if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(0, WPL + 1));
        drive(1'b1, 10'($urandom_range(0, 599)), 1'b0, 10'd0);
      end
      idle(WPL + 3);
      sweep(680, 1'b1);
    end

    idle(3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (addr_q.size() != 0 || col_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", addr_q.size(), col_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
